// File: rtl/bt656_pkg.sv
// Shared constants, FSM states and XY helpers for the BT.656 TRS regenerator.
// Optional active-video clipping is compiled in with BT656_CLIP_EN.
package bt656_pkg;

    localparam logic [9:0]  TRS_PRE_FIRST = 10'h3FF;
    localparam logic [9:0]  TRS_PRE_ZERO  = 10'h000;

    localparam int unsigned LINE_WORDS  = 1716;
    localparam int unsigned BLANK_WORDS = 268;
    localparam int unsigned MISS_LIMIT  = 2;

    localparam logic [10:0] EAV_FIRST_POS = 11'd0;
    localparam logic [10:0] EAV_XY_POS    = 11'd3;
    localparam logic [10:0] SAV_FIRST_POS = 11'(4 + BLANK_WORDS);
    localparam logic [10:0] SAV_XY_POS    = 11'(7 + BLANK_WORDS);
    localparam logic [10:0] LAST_POS      = 11'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_COAST    = 2'd2
    } trs_state_e;

    function automatic logic [9:0] xy_word(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

    // A legal XY is exactly what xy_word rebuilds from its own F/V/H bits.
    function automatic logic xy_check(input logic [9:0] word);
        return (word == xy_word(word[8], word[7], word[6]));
    endfunction

`ifdef BT656_CLIP_EN
    function automatic logic [9:0] clip_active(input logic [9:0] word);
        if (word <= 10'h003) begin
            return 10'h004;
        end else if (word >= 10'h3FC) begin
            return 10'h3FB;
        end else begin
            return word;
        end
    endfunction
`endif

endpackage

// File: rtl/bt656_trs_regenerator_if.sv
// Word stream and status bundle between the rotator side and the TRS regenerator.
interface bt656_trs_regenerator_if;
    logic [9:0]  data_in;
    logic        data_valid;
    logic [9:0]  data_out;
    logic        data_out_valid;
    logic        locked;
    logic [10:0] sample_count;
    logic [9:0]  line_count;
    logic        f_out;
    logic        v_out;
    logic        h_out;
    logic        trs_error;

    modport master (
        output data_in, data_valid,
        input  data_out, data_out_valid, locked, sample_count, line_count,
        input  f_out, v_out, h_out, trs_error
    );

    modport slave (
        input  data_in, data_valid,
        output data_out, data_out_valid, locked, sample_count, line_count,
        output f_out, v_out, h_out, trs_error
    );
endinterface

// File: rtl/trs_detector.sv
// Input TRS detector: 3-word preamble history plus XY decode and protection check.
module trs_detector
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [9:0] i_data,
    output logic       o_trs_det,
    output logic       o_eav_det,
    output logic       o_sav_det,
    output logic       o_xy_ok,
    output logic       o_f,
    output logic       o_v
);
    // r_pre[2] is the oldest of the three previous qualified words.
    logic [2:0][9:0] r_pre;
    logic            w_preamble;

    // Preamble history shifts only on qualified words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (i_valid) begin
            r_pre <= {r_pre[1:0], i_data};
        end else begin
            r_pre <= r_pre;
        end
    end

    assign w_preamble = i_valid && (r_pre[2] == TRS_PRE_FIRST) &&
                        (r_pre[1] == TRS_PRE_ZERO) && (r_pre[0] == TRS_PRE_ZERO);
    assign o_trs_det  = w_preamble;
    assign o_xy_ok    = w_preamble && xy_check(i_data);
    assign o_eav_det  = o_xy_ok && i_data[6];
    assign o_sav_det  = o_xy_ok && !i_data[6];
    assign o_f        = i_data[8];
    assign o_v        = i_data[7];

endmodule

// File: rtl/bt656_trs_regenerator.sv
// Flywheel TRS regenerator: rebuilds EAV/SAV at predicted positions and tracks lock.
// Defining BT656_CLIP_EN clips active words out of the reserved 0x000-0x003/0x3FC-0x3FF codes.
module bt656_trs_regenerator
    import bt656_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    bt656_trs_regenerator_if.slave        bus
);
    localparam int unsigned MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [9:0]  LINE_MAX = 10'd1023;

    trs_state_e        r_state, w_state_next;
    logic [10:0]       r_sample, w_idx, w_n_next;
    logic [MISS_W-1:0] r_miss, w_miss_next, w_miss_inc;
    logic              r_f, r_v, w_f_next, w_v_next;
    logic [9:0]        r_line, w_line_next;
    logic [9:0]        r_data_out, w_out;
    logic              r_data_out_valid, r_locked, r_h, r_trs_error;
    logic              w_h_next, w_err, w_xy_slot, w_regen;
    logic              w_trs_det, w_eav_det, w_sav_det, w_xy_ok, w_det_f, w_det_v;

    trs_detector u_detector (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (bus.data_valid),
        .i_data    (bus.data_in),
        .o_trs_det (w_trs_det),
        .o_eav_det (w_eav_det),
        .o_sav_det (w_sav_det),
        .o_xy_ok   (w_xy_ok),
        .o_f       (w_det_f),
        .o_v       (w_det_v)
    );

    assign w_n_next   = (r_sample == LAST_POS) ? EAV_FIRST_POS : r_sample + 11'd1;
    assign w_miss_inc = r_miss + MISS_W'(1);

    // Lock FSM: compare detected EAVs against the flywheel-predicted XY slot.
    always_comb begin
        w_state_next = r_state;
        w_idx        = r_sample;
        w_miss_next  = r_miss;
        w_f_next     = r_f;
        w_v_next     = r_v;
        w_xy_slot    = 1'b0;
        w_err        = w_trs_det && !w_xy_ok;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_eav_det) begin
                    w_state_next = ST_LOCKED;
                    w_idx        = EAV_XY_POS;
                    w_miss_next  = '0;
                    w_f_next     = w_det_f;
                    w_v_next     = w_det_v;
                    w_xy_slot    = 1'b1;
                end else begin
                    w_state_next = ST_UNLOCKED;
                end
            end
            ST_LOCKED, ST_COAST: begin
                if (w_eav_det) begin
                    // A misplaced EAV still wins: resync onto it and flag the jump.
                    w_state_next = ST_LOCKED;
                    w_idx        = EAV_XY_POS;
                    w_miss_next  = '0;
                    w_f_next     = w_det_f;
                    w_v_next     = w_det_v;
                    w_xy_slot    = 1'b1;
                    w_err        = w_err || (w_n_next != EAV_XY_POS);
                end else if (w_n_next == EAV_XY_POS) begin
                    w_idx       = w_n_next;
                    w_miss_next = w_miss_inc;
                    if (w_miss_inc >= MISS_W'(MISS_LIMIT)) begin
                        w_state_next = ST_UNLOCKED;
                    end else begin
                        w_state_next = ST_COAST;
                        w_xy_slot    = 1'b1;
                    end
                end else begin
                    w_idx = w_n_next;
                end
            end
            default: begin
                w_state_next = ST_UNLOCKED;
            end
        endcase
    end

    // Output word, H flag and line counter for the word being registered.
    always_comb begin
        w_regen     = (w_state_next != ST_UNLOCKED);
        w_out       = bus.data_in;
        w_h_next    = r_h;
        w_line_next = r_line;
        if (w_regen) begin
            w_h_next = (w_idx <= SAV_XY_POS);
            if (w_idx == EAV_FIRST_POS || w_idx == SAV_FIRST_POS) begin
                w_out = TRS_PRE_FIRST;
            end else if (w_idx < EAV_XY_POS || (w_idx > SAV_FIRST_POS && w_idx < SAV_XY_POS)) begin
                w_out = TRS_PRE_ZERO;
            end else if (w_idx == EAV_XY_POS) begin
                w_out = xy_word(w_f_next, w_v_next, 1'b1);
            end else if (w_idx == SAV_XY_POS) begin
                w_out = xy_word(w_f_next, w_v_next, 1'b0);
`ifdef BT656_CLIP_EN
            end else if (w_idx > SAV_XY_POS) begin
                w_out = clip_active(bus.data_in);
`endif
            end else begin
                w_out = bus.data_in;
            end
        end else begin
            w_out    = bus.data_in;
            w_h_next = w_sav_det ? 1'b0 : r_h;
        end
        if (r_f && !w_f_next) begin
            w_line_next = '0;
        end else if (w_xy_slot && (r_line != LINE_MAX)) begin
            w_line_next = r_line + 10'd1;
        end else begin
            w_line_next = r_line;
        end
    end

    // State and output registers; a low data_valid freezes everything but the valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_UNLOCKED;
            r_sample         <= '0;
            r_miss           <= '0;
            r_f              <= 1'b0;
            r_v              <= 1'b0;
            r_line           <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_locked         <= 1'b0;
            r_h              <= 1'b0;
            r_trs_error      <= 1'b0;
        end else begin
            r_data_out_valid <= bus.data_valid;
            if (bus.data_valid) begin
                r_state     <= w_state_next;
                r_sample    <= w_idx;
                r_miss      <= w_miss_next;
                r_f         <= w_f_next;
                r_v         <= w_v_next;
                r_line      <= w_line_next;
                r_data_out  <= w_out;
                r_locked    <= w_regen;
                r_h         <= w_h_next;
                r_trs_error <= w_err;
            end else begin
                r_trs_error <= 1'b0;
            end
        end
    end

    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_data_out_valid;
    assign bus.locked         = r_locked;
    assign bus.sample_count   = r_sample;
    assign bus.line_count     = r_line;
    assign bus.f_out          = r_f;
    assign bus.v_out          = r_v;
    assign bus.h_out          = r_h;
    assign bus.trs_error      = r_trs_error;

endmodule

// File: tb/tb_bt656_trs_regenerator.sv
// Directed self-checking bench for bt656_trs_regenerator (clip expectations follow BT656_CLIP_EN).
module tb_bt656_trs_regenerator;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   err_pulses = 0;

    bt656_trs_regenerator_if bus();

    bt656_trs_regenerator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Hand-computed XY codes: EAV/SAV for F0V0, F0V1, F1V0.
    localparam logic [9:0] EAV_00 = 10'h274;
    localparam logic [9:0] SAV_00 = 10'h200;
    localparam logic [9:0] EAV_01 = 10'h2D8;
    localparam logic [9:0] SAV_01 = 10'h2AC;
    localparam logic [9:0] EAV_10 = 10'h368;
    localparam logic [9:0] SAV_10 = 10'h31C;
    localparam logic [9:0] NO_EAV = 10'h000;

`ifdef BT656_CLIP_EN
    localparam logic [9:0] EXP_LO = 10'h004;
    localparam logic [9:0] EXP_HI = 10'h3FB;
`else
    localparam logic [9:0] EXP_LO = 10'h000;
    localparam logic [9:0] EXP_HI = 10'h3FF;
`endif

    logic [9:0] regen [4] = '{10'h3FF, 10'h000, 10'h000, 10'h274};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Line content; NO_EAV as eav_xy replaces words 0-3 with blanking.
    function automatic logic [9:0] line_word(input int idx, input logic [9:0] eav_xy, input logic [9:0] sav_xy);
        logic [9:0] w;
        if (eav_xy == NO_EAV && idx < 4)      w = (idx % 2 == 0) ? 10'h200 : 10'h040;
        else if (idx == 0 || idx == 272)      w = 10'h3FF;
        else if (idx == 1 || idx == 2 || idx == 273 || idx == 274) w = 10'h000;
        else if (idx == 3)                    w = eav_xy;
        else if (idx == 275)                  w = sav_xy;
        else if (idx < 272)                   w = (idx % 2 == 0) ? 10'h200 : 10'h040;
        else                                  w = 10'h040 + 10'(idx % 400);
        return w;
    endfunction

    task automatic drive(input logic [9:0] w);
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        if (bus.trs_error === 1'b1) err_pulses++;
    endtask

    task automatic send_range(input logic [9:0] eav_xy, input logic [9:0] sav_xy,
                              input int from, input int to, input bit chk_pass, input bit chk_idx);
        logic [9:0] w;
        for (int i = from; i < to; i++) begin
            w = line_word(i, eav_xy, sav_xy);
            drive(w);
            if (chk_pass) check_eq("pass", bus.data_out, w);
            if (chk_idx) begin
                check_eq("sample_count", bus.sample_count, i);
                check_eq("h_out", bus.h_out, (i <= 275) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_data_out"}, bus.data_out, 32'd0);
        check_eq({tag, "_valid"}, bus.data_out_valid, 32'd0);
        check_eq({tag, "_locked"}, bus.locked, 32'd0);
        check_eq({tag, "_sample"}, bus.sample_count, 32'd0);
        check_eq({tag, "_line"}, bus.line_count, 32'd0);
        check_eq({tag, "_fvh"}, {bus.f_out, bus.v_out, bus.h_out}, 32'd0);
        check_eq({tag, "_trs_error"}, bus.trs_error, 32'd0);
    endtask

    initial begin
        bus.data_in    = 10'h000;
        bus.data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;

        // Line 1 (F0V1): lock at the first EAV XY.
        send_range(EAV_01, SAV_01, 0, 3, 1'b1, 1'b0);
        send_range(EAV_01, SAV_01, 3, 4, 1'b1, 1'b0);
        check_eq("lock_locked", bus.locked, 32'd1);
        check_eq("lock_sample", bus.sample_count, 32'd3);
        check_eq("lock_line", bus.line_count, 32'd1);
        check_eq("lock_fvh", {bus.f_out, bus.v_out, bus.h_out}, 32'b011);
        send_range(EAV_01, SAV_01, 4, 1716, 1'b1, 1'b1);

        // Line 2 (F0V0): clean, exercises the 1715 -> 0 wrap.
        send_range(EAV_00, SAV_00, 0, 1716, 1'b1, 1'b1);
        check_eq("l2_line", bus.line_count, 32'd2);
        check_eq("l2_v", bus.v_out, 32'd0);
        check_eq("clean_err", err_pulses, 32'd0);

        // Line 3: corrupted XY -> regenerated EAV, error pulse, coast.
        err_pulses = 0;
        send_range(EAV_00, SAV_00, 0, 3, 1'b1, 1'b1);
        drive(10'h2A4);
        check_eq("bad_xy_out", bus.data_out, 32'h274);
        check_eq("bad_xy_err", bus.trs_error, 32'd1);
        check_eq("bad_xy_locked", bus.locked, 32'd1);
        check_eq("bad_xy_sample", bus.sample_count, 32'd3);
        send_range(EAV_00, SAV_00, 4, 1716, 1'b1, 1'b1);
        send_range(EAV_00, SAV_00, 0, 1716, 1'b1, 1'b1);
        check_eq("bad_xy_err_count", err_pulses, 32'd1);

        // Line 5: EAV arrives 5 words late -> resync to 3, stays locked.
        err_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 10'h200 : 10'h040);
            check_eq("shift_pre", bus.data_out, (i < 4) ? {22'd0, regen[i]} : 32'h200);
        end
        send_range(EAV_00, SAV_00, 0, 3, 1'b1, 1'b0);
        drive(EAV_00);
        check_eq("shift_err", bus.trs_error, 32'd1);
        check_eq("shift_sample", bus.sample_count, 32'd3);
        check_eq("shift_locked", bus.locked, 32'd1);
        check_eq("shift_out", bus.data_out, 32'h274);
        send_range(EAV_00, SAV_00, 4, 1716, 1'b1, 1'b1);
        check_eq("shift_err_count", err_pulses, 32'd1);

        // Line 6: data_valid gap freezes counters and holds data_out.
        err_pulses = 0;
        send_range(EAV_00, SAV_00, 0, 500, 1'b1, 1'b1);
        bus.data_valid = 1'b0;
        bus.data_in    = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("gap_valid", bus.data_out_valid, 32'd0);
            check_eq("gap_hold", bus.data_out, line_word(499, EAV_00, SAV_00));
            check_eq("gap_sample", bus.sample_count, 32'd499);
        end
        send_range(EAV_00, SAV_00, 500, 1716, 1'b1, 1'b1);
        check_eq("gap_valid_back", bus.data_out_valid, 32'd1);

        // Lines 7-8: EAV missing twice -> coast, then unlock and pass-through.
        for (int i = 0; i < 4; i++) begin
            drive(line_word(i, NO_EAV, SAV_01));
            check_eq("miss1_regen", bus.data_out, regen[i]);
        end
        check_eq("miss1_locked", bus.locked, 32'd1);
        send_range(NO_EAV, SAV_01, 4, 275, 1'b1, 1'b1);
        drive(SAV_01);
        check_eq("coast_sav", bus.data_out, 32'h200);
        send_range(NO_EAV, SAV_01, 276, 1716, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(line_word(i, NO_EAV, SAV_01));
            check_eq("miss2_regen", bus.data_out, regen[i]);
        end
        drive(line_word(3, NO_EAV, SAV_01));
        check_eq("miss2_out", bus.data_out, 32'h040);
        check_eq("miss2_locked", bus.locked, 32'd0);
        send_range(NO_EAV, SAV_01, 4, 1716, 1'b1, 1'b0);
        check_eq("unlocked_still", bus.locked, 32'd0);
        check_eq("miss_err_count", err_pulses, 32'd0);

        // Line 9: relock; line 10: reset at word 800.
        send_range(EAV_00, SAV_00, 0, 3, 1'b1, 1'b0);
        drive(EAV_00);
        check_eq("relock_locked", bus.locked, 32'd1);
        check_eq("relock_sample", bus.sample_count, 32'd3);
        send_range(EAV_00, SAV_00, 4, 1716, 1'b1, 1'b1);
        send_range(EAV_00, SAV_00, 0, 800, 1'b1, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        reset_n = 1'b1;
        send_range(EAV_00, SAV_00, 801, 1716, 1'b1, 1'b0);
        check_eq("post_reset_locked", bus.locked, 32'd0);

        // Line 11: fresh EAV relocks with a cleared line counter.
        send_range(EAV_00, SAV_00, 0, 3, 1'b1, 1'b0);
        drive(EAV_00);
        check_eq("reset_relock", bus.locked, 32'd1);
        check_eq("reset_relock_line", bus.line_count, 32'd1);
        send_range(EAV_00, SAV_00, 4, 1716, 1'b1, 1'b1);

        // Line 12 (F1), line 13 (F0): F 1->0 clears line_count.
        send_range(EAV_10, SAV_10, 0, 1716, 1'b1, 1'b1);
        check_eq("f1_f_out", bus.f_out, 32'd1);
        check_eq("f1_line", bus.line_count, 32'd2);
        send_range(EAV_00, SAV_00, 0, 4, 1'b1, 1'b1);
        check_eq("f_fall_line", bus.line_count, 32'd0);
        check_eq("f_fall_f_out", bus.f_out, 32'd0);

        // Same line: reserved codes in blanking and active video.
        send_range(EAV_00, SAV_00, 4, 100, 1'b1, 1'b1);
        drive(10'h000);
        check_eq("blank_zero", bus.data_out, 32'h000);
        send_range(EAV_00, SAV_00, 101, 300, 1'b1, 1'b1);
        drive(10'h000);
        check_eq("active_lo", bus.data_out, EXP_LO);
        drive(10'h3FF);
        check_eq("active_hi", bus.data_out, EXP_HI);
        send_range(EAV_00, SAV_00, 302, 1716, 1'b1, 1'b1);
        check_eq("tail_err_count", err_pulses, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bt656_trs_regenerator.md
# bt656_trs_regenerator

Downstream stage of `line_rotator` in the descrambler path. It takes the rotated BT.656 word stream and rebuilds clean timing reference sequences (EAV/SAV) with correct F/V/H and protection bits at flywheel-predicted positions. It also optionally clips active-video words out of the reserved 0x000/0x3FF range, so the recovered stream is legal BT.656 for the encoder/output interface. It reports lock state, line/sample position and TRS errors.

## Interface
- `LINE_WORDS`, 1716: words per line (858 samples × 2).
- `BLANK_WORDS`, 268: horizontal blanking words between EAV and SAV.
- `MISS_LIMIT`, 2: consecutive missing EAVs tolerated before unlock.
- `clk`  in  1  pixel-word clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  10  word from `line_rotator.data_out`.
- `data_valid`  in  1  qualifies `data_in`; when low, all counters hold.
- `data_out`  out  10  regenerated stream.
- `data_out_valid`  out  1  registered copy of `data_valid`.
- `locked`  out  1  high in LOCKED or COAST.
- `sample_count`  out  11  word index in line, 0 = first EAV word.
- `line_count`  out  10  line index within frame.
- `f_out`, `v_out`, `h_out`  out  1 each  current timing flags.
- `trs_error`  out  1  one-cycle pulse on EAV position mismatch or protection-bit error.

## Operation
- A TRS is 3FF,000,000,XY. XY = {1, F, V, H, F^.. protection: V^H, F^H, F^V, F^V^H, 2'b00}.
- Input detector: 3-word preamble shift register plus current word. A detected XY with a failed protection check raises `trs_error` and is ignored.
- The FSM has three states: UNLOCKED, LOCKED and COAST.
- UNLOCKED:
  - `data_out` = `data_in` (no clip).
  - On a valid input EAV (H=1): `sample_count` := 3 at the XY word, latch F/V, go to LOCKED.
- LOCKED:
  - `sample_count` free-runs modulo `LINE_WORDS`.
  - Output words 0–3 are replaced by EAV (H=1).
  - Words `4+BLANK_WORDS`..`7+BLANK_WORDS` (272–275) are replaced by SAV (H=0), using the latched F/V.
  - Blanking and active words pass through.
  - Input EAV at the predicted index 3: latch F/V, clear the miss counter.
  - Input EAV elsewhere: pulse `trs_error`, resync `sample_count` to 3, stay LOCKED.
  - No EAV at index 3: increment the miss counter and go to COAST.
- COAST:
  - Same output behaviour as LOCKED, with F/V held.
  - Correct EAV: back to LOCKED, miss counter := 0.
  - Miss counter reaches `MISS_LIMIT`: go to UNLOCKED.
- `line_count`:
  - Increments at each EAV XY word.
  - Cleared to 0 when latched F goes 1→0.
  - Saturates at 1023.
- `h_out` = 1 from EAV to SAV (words 0–275), else 0.

## Timing
- Latency is one cycle: `data_out`/`data_out_valid` are registered from `data_in`/`data_valid`.
- `data_valid` low freezes the detector, counters and FSM; `data_out_valid` goes low the next cycle and `data_out` holds.
- Reset values: `data_out` 0, `data_out_valid` 0, `locked` 0, `sample_count` 0, `line_count` 0, flags 0, `trs_error` 0, FSM UNLOCKED.
- Reset mid-line: everything returns to reset values immediately; relock requires a fresh EAV.
- Simultaneous detection of a bad-protection XY and a predicted index 3: counts as a miss (COAST) and pulses `trs_error` once.
- Wrap: index `LINE_WORDS-1` → 0 in the same cycle the next EAV's 3FF is output.

## Configuration
- `BT656_CLIP_EN` defined: in LOCKED/COAST, active words (276–1715) with value 0x000–0x003 are output as 0x004, and 0x3FC–0x3FF as 0x3FB.
- Undefined: active words pass unchanged; the clip logic is absent.

## Structure
- Package `bt656_pkg` holds:
  - the TRS preamble constants;
  - the EAV/SAV position constants;
  - the FSM state enum;
  - function `xy_word(f, v, h)`;
  - function `xy_check(word)`.
- Sub-module `trs_detector` holds the preamble shift register and XY decode/check. It outputs `eav_det`, `sav_det`, `xy_ok`, `f`, `v`.

## Test plan
- Clean frame of 525×1716 words -> `locked`=1 after the first EAV; output is bit-identical to input except the TRS words, which already match; no `trs_error`.
- EAV XY word corrupted to 0x2A4 on one line -> `trs_error` pulse, state COAST, regenerated EAV 3FF,000,000,XY still output at words 0–3; LOCKED again next line.
- Two consecutive lines with EAV removed -> UNLOCKED after the second miss, `locked`=0, pass-through resumes.
- EAV shifted by +5 words -> `trs_error` pulse, `sample_count` resyncs to 3 at the new XY, remains LOCKED.
- With `BT656_CLIP_EN`, active words 0x000 and 0x3FF -> 0x004 and 0x3FB; blanking word 0x000 is unchanged.
- Assert `reset_n`=0 at word 800 -> all outputs 0 on the next edge, UNLOCKED until the next valid EAV.
